// File: rtl/nonrestoring_divider.sv
// Sequential unsigned divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Operands arrive serially on inbus (D_lo, D_hi, V); result is {remainder, quotient} on outbus.
module nonrestoring_divider #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   inbus,
   output logic [2*W-1:0] outbus,
   output logic           stop,
   output logic           err
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {IDLE, LD_HI, LD_DV, CHECK, ITER, FIX, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  d_lo, d_hi, v, q;
   logic [W+1:0]  r;
   logic [CW-1:0] cnt;

   logic          div_err;
   logic [W+1:0]  vx, t, r_step;
   logic [W-1:0]  rem;

   // r is a two's-complement partial remainder; its MSB is the sign.
   always_comb begin
      vx      = {2'b00, v};
      t       = {r[W:0], q[W-1]};
      r_step  = r[W+1] ? (t + vx) : (t - vx);
      rem     = r[W+1] ? (r[W-1:0] + v) : r[W-1:0];
      div_err = (v == '0) || (d_hi >= v);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = LD_HI;
         LD_HI:   state_nxt = LD_DV;
         LD_DV:   state_nxt = CHECK;
         CHECK:   state_nxt = div_err ? DONE : ITER;
         ITER:    if (cnt == CW'(W - 1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (start) state_nxt = LD_HI;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_lo   <= '0;
         d_hi   <= '0;
         v      <= '0;
         q      <= '0;
         r      <= '0;
         cnt    <= '0;
         outbus <= '0;
         stop   <= 1'b0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: if (start) begin
               d_lo <= inbus;
               stop <= 1'b0;
               err  <= 1'b0;
            end
            LD_HI: d_hi <= inbus;
            LD_DV: v    <= inbus;
            CHECK: begin
               if (div_err) begin
                  outbus <= '1;
                  err    <= 1'b1;
                  stop   <= 1'b1;
               end else begin
                  r   <= {2'b00, d_hi};
                  q   <= d_lo;
                  cnt <= '0;
               end
            end
            ITER: begin
               r   <= r_step;
               q   <= {q[W-2:0], ~r_step[W+1]};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               outbus <= {rem, q};
               err    <= 1'b0;
               stop   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
